// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the fetch program counter.
// Next-PC source selection and alignment utilities.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_REDIRECT,
        SRC_CALL,
        SRC_RET
    } pc_src_e;

    localparam int unsigned INSTR_BYTES_DFLT = 4;
    localparam int unsigned ALIGN_BITS       = $clog2(INSTR_BYTES_DFLT);

    // Mask that clears the low `bits` address bits.
    function automatic logic [63:0] align_mask(input int unsigned bits);
        logic [63:0] ones;
        ones = (64'd1 << bits) - 64'd1;
        return ~ones;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry.
// Replace rewrites the top in place (call and return in one fetch).
module pc_ras
    import pc_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         replace,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          uf_q, uf_d;
    logic [PW-1:0] top_idx;

    // ptr_q is the next free slot; the top entry sits just below it.
    assign top_idx   = ptr_q - PW'(1);
    assign top       = mem_q[top_idx];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign underflow = uf_q;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        uf_d  = 1'b0;
        if (flush) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (replace) begin
            if (empty) begin
                mem_d[ptr_q] = wdata;
                ptr_d        = ptr_q + PW'(1);
                cnt_d        = CW'(1);
                uf_d         = 1'b1;
            end else begin
                mem_d[top_idx] = wdata;
            end
        end else if (push) begin
            mem_d[ptr_q] = wdata;
            ptr_d        = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                uf_d = 1'b1;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch program counter with redirect, call/return prediction and
// a valid/ready handshake toward instruction fetch.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned     INSTR_BYTES = 1 << ALIGN_BITS,
    parameter int unsigned     RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            ras_flush,
    input  logic            call_valid,
    input  logic [XLEN-1:0] call_pc,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign_err,
    output logic            ras_underflow
);

    localparam int unsigned     AB   = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(AB));
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;

    pc_src_e         src;
    logic            accept;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] chk_addr;
    logic            chk_en;
    logic            ras_push, ras_pop, ras_repl, ras_clr;
    logic [XLEN-1:0] ras_top;

    assign accept  = fetch_ready & pc_valid_q;
    assign pc_plus = pc_q + STEP;
    assign ras_clr = redirect_valid & ras_flush;

    // Source selection: redirect wins, then return, then call.
    always_comb begin
        src      = SRC_HOLD;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_repl = 1'b0;
        chk_addr = '0;
        chk_en   = 1'b0;
        if (redirect_valid) begin
            src      = SRC_REDIRECT;
            chk_addr = redirect_pc;
            chk_en   = 1'b1;
        end else if (accept && ret_valid) begin
            src      = ras_empty ? SRC_SEQ : SRC_RET;
            ras_pop  = !call_valid;
            ras_repl = call_valid;
        end else if (accept && call_valid) begin
            src      = SRC_CALL;
            ras_push = 1'b1;
            chk_addr = call_pc;
            chk_en   = 1'b1;
        end else if (accept) begin
            src = SRC_SEQ;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src)
            SRC_REDIRECT: pc_d = redirect_pc & MASK;
            SRC_CALL:     pc_d = call_pc & MASK;
            SRC_RET:      pc_d = ras_top;
            SRC_SEQ:      pc_d = pc_plus;
            default:      pc_d = pc_q;
        endcase
        misalign_d = chk_en && ((chk_addr & ~MASK) != '0);
        pc_valid_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_repl),
        .flush     (ras_clr),
        .wdata     (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .underflow (ras_underflow)
    );

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ras_flush = 1'b0;
    logic        call_valid = 1'b0;
    logic [31:0] call_pc = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign_err;
    logic        ras_underflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ras[$];
    logic        m_mis;
    logic        m_uf;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ras_flush      (ras_flush),
        .call_valid     (call_valid),
        .call_pc        (call_pc),
        .ret_valid      (ret_valid),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .misalign_err   (misalign_err),
        .ras_underflow  (ras_underflow)
    );

    task automatic model_reset();
        m_pc = 32'h0;
        m_valid = 1'b0;
        m_ras.delete();
        m_mis = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic model_edge(input logic fr, rd, fl, cv, rv,
                              input logic [31:0] rpc, cpc);
        logic        acc;
        logic [31:0] npc;
        acc = fr && m_valid;
        npc = m_pc;
        m_mis = 1'b0;
        m_uf = 1'b0;
        if (rd) begin
            npc = {rpc[31:2], 2'b00};
            m_mis = (rpc % 4) != 0;
            if (fl) m_ras.delete();
        end else if (acc && rv && cv) begin
            if (m_ras.size() > 0) begin
                npc = m_ras[$];
                m_ras[m_ras.size() - 1] = m_pc + 32'd4;
            end else begin
                npc = m_pc + 32'd4;
                m_ras.push_back(m_pc + 32'd4);
                m_uf = 1'b1;
            end
        end else if (acc && rv) begin
            if (m_ras.size() > 0) begin
                npc = m_ras.pop_back();
            end else begin
                npc = m_pc + 32'd4;
                m_uf = 1'b1;
            end
        end else if (acc && cv) begin
            npc = {cpc[31:2], 2'b00};
            m_mis = (cpc % 4) != 0;
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (acc) begin
            npc = m_pc + 32'd4;
        end
        m_pc = npc;
        m_valid = 1'b1;
    endtask

    task automatic step(input logic fr, rd, fl, cv, rv,
                        input logic [31:0] rpc, cpc);
        fetch_ready = fr;
        redirect_valid = rd;
        ras_flush = fl;
        call_valid = cv;
        ret_valid = rv;
        redirect_pc = rpc;
        call_pc = cpc;
        model_edge(fr, rd, fl, cv, rv, rpc, cpc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({pc, pc_valid, ras_empty, ras_full, misalign_err, ras_underflow}
            !== {32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset: got pc=%h v=%b e=%b f=%b mis=%b uf=%b",
                     pc, pc_valid, ras_empty, ras_full, misalign_err, ras_underflow);
        else pass_cnt++;
    endtask

    task automatic test_boot();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        fetch_ready = 1'b1;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 32'h0 || pc_valid !== 1'b0)
            $display("FAIL boot_c1: got pc=%h v=%b exp pc=0 v=0", pc, pc_valid);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            total_cnt++;
            if (pc !== exp_pc[i] || pc_valid !== 1'b1)
                $display("FAIL boot_seq%0d: got pc=%h v=%b exp pc=%h v=1",
                         i, pc, pc_valid, exp_pc[i]);
            else pass_cnt++;
        end
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stall_redirect();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            total_cnt++;
            if (pc !== 32'h10)
                $display("FAIL stall%0d: got pc=%h exp 00000010", i, pc);
            else pass_cnt++;
        end
        step(0, 1, 0, 0, 0, 32'h203, 0);
        total_cnt++;
        if (pc !== 32'h200 || misalign_err !== 1'b1)
            $display("FAIL redirect_mis: got pc=%h mis=%b exp pc=200 mis=1",
                     pc, misalign_err);
        else pass_cnt++;
        step(0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (pc !== 32'h200 || misalign_err !== 1'b0)
            $display("FAIL mis_pulse: got pc=%h mis=%b exp pc=200 mis=0",
                     pc, misalign_err);
        else pass_cnt++;
    endtask

    task automatic test_call_ret();
        step(0, 1, 0, 0, 0, 32'h100, 0);
        step(1, 0, 0, 1, 0, 0, 32'h400);
        total_cnt++;
        if (pc !== 32'h400 || ras_empty !== 1'b0)
            $display("FAIL call: got pc=%h e=%b exp pc=400 e=0", pc, ras_empty);
        else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        total_cnt++;
        if (pc !== 32'h104 || ras_empty !== 1'b1)
            $display("FAIL ret: got pc=%h e=%b exp pc=104 e=1", pc, ras_empty);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [5] =
            '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'h1008};
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 1, 0, 0, 32'h1000 * (i + 1));
        total_cnt++;
        if (ras_full !== 1'b1 || pc !== 32'h5000)
            $display("FAIL ovf_full: got full=%b pc=%h exp full=1 pc=5000",
                     ras_full, pc);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 1, 0, 0);
            total_cnt++;
            if (pc !== exp_ret[i] || ras_underflow !== (i == 4))
                $display("FAIL ovf_ret%0d: got pc=%h uf=%b exp pc=%h uf=%b",
                         i, pc, ras_underflow, exp_ret[i], i == 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        step(0, 1, 0, 0, 0, 32'h4FC, 0);
        step(1, 0, 0, 1, 0, 0, 32'h300);
        step(1, 0, 0, 1, 1, 0, 32'h900);
        total_cnt++;
        if (pc !== 32'h500 || ras_empty !== 1'b0 || ras_underflow !== 1'b0)
            $display("FAIL callret: got pc=%h e=%b uf=%b exp pc=500 e=0 uf=0",
                     pc, ras_empty, ras_underflow);
        else pass_cnt++;
        step(1, 0, 0, 0, 1, 0, 0);
        total_cnt++;
        if (pc !== 32'h304 || ras_empty !== 1'b1)
            $display("FAIL callret_top: got pc=%h e=%b exp pc=304 e=1",
                     pc, ras_empty);
        else pass_cnt++;
        step(1, 0, 0, 1, 0, 0, 32'h600);
        step(1, 1, 1, 0, 0, 32'h700, 0);
        total_cnt++;
        if (pc !== 32'h700 || ras_empty !== 1'b1)
            $display("FAIL flush: got pc=%h e=%b exp pc=700 e=1", pc, ras_empty);
        else pass_cnt++;
        step(1, 0, 0, 0, 1, 0, 0);
        total_cnt++;
        if (pc !== 32'h704 || ras_underflow !== 1'b1)
            $display("FAIL flush_uf: got pc=%h uf=%b exp pc=704 uf=1",
                     pc, ras_underflow);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (pc !== 32'h0)
            $display("FAIL wrap: got pc=%h exp 00000000", pc);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        fr, rd, fl, cv, rv;
        logic [31:0] rpc, cpc;
        for (int i = 0; i < 400; i++) begin
            fr = $urandom_range(3) != 0;
            rd = $urandom_range(9) == 0;
            fl = $urandom_range(2) == 0;
            cv = $urandom_range(4) == 0;
            rv = $urandom_range(4) == 0;
            rpc = $urandom();
            cpc = $urandom();
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(3) != 0) cpc[1:0] = 2'b00;
            step(fr, rd, fl, cv, rv, rpc, cpc);
            total_cnt++;
            if ({pc, pc_valid, ras_empty, ras_full, misalign_err, ras_underflow}
                !== {m_pc, m_valid, m_ras.size() == 0, m_ras.size() == 4,
                     m_mis, m_uf})
                $display("FAIL rand%0d: got pc=%h e=%b f=%b mis=%b uf=%b exp pc=%h e=%b f=%b mis=%b uf=%b",
                         i, pc, ras_empty, ras_full, misalign_err, ras_underflow,
                         m_pc, m_ras.size() == 0, m_ras.size() == 4, m_mis, m_uf);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0, 0, 32'h800, 0);
        step(1, 0, 0, 1, 0, 0, 32'hA00);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || ras_empty !== 1'b1)
            $display("FAIL async_rst: got pc=%h v=%b e=%b exp pc=0 v=0 e=1",
                     pc, pc_valid, ras_empty);
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (pc !== 32'h4 || pc_valid !== 1'b1)
            $display("FAIL reboot: got pc=%h v=%b exp pc=4 v=1", pc, pc_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall_redirect();
        test_call_ret();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-register program counter; generates the fetch PC each cycle.
- Next-PC selection: sequential increment, resolved redirect, call target, or return-address-stack pop.
- Valid/ready handshake toward instruction fetch; an internal return-address stack (RAS) predicts returns.
- Sits between the branch/jump resolution logic and the instruction memory address port.

Parameters:
- XLEN, 32: PC width in bits.
- RESET_VEC, 32'h0000_0000: PC value loaded by reset.
- INSTR_BYTES, 4: sequential increment; power of two; defines the alignment mask.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  fetch stage accepts the current pc this cycle.
- redirect_valid  in  1  resolved branch or jump; overrides everything.
- redirect_pc  in  XLEN  redirect target.
- ras_flush  in  1  clears the RAS; honoured only with redirect_valid.
- call_valid  in  1  current pc is a call; push the return address.
- call_pc  in  XLEN  call target.
- ret_valid  in  1  current pc is a return; pop the RAS.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is presentable to fetch.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count equals RAS_DEPTH.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect or call target.
- ras_underflow  out  1  one-cycle pulse when a pop is attempted on an empty RAS.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = RESET_VEC, pc_valid = 0.
  - RAS count = 0, top pointer = 0, ras_empty = 1, ras_full = 0.
  - All error pulses = 0.
- First rising edge after release sets pc_valid = 1 and leaves pc unchanged. pc_valid then stays 1 until the next reset.
- Handshake:
  - A fetch is accepted when fetch_ready = 1 and pc_valid = 1.
  - Without acceptance and without redirect, pc holds.
  - call_valid and ret_valid are sampled only on an accepted fetch.
- Next-PC priority, registered, 1-cycle latency:
  1. redirect_valid: pc <= redirect_pc with the low log2(INSTR_BYTES) bits cleared. Applies even when not accepted and even while pc_valid = 0. call_valid and ret_valid are ignored that cycle. If ras_flush = 1, RAS count and top pointer go to 0.
  2. Accepted fetch with ret_valid and RAS non-empty: pc <= top entry, count decrements.
  3. Accepted fetch with ret_valid and RAS empty: pc <= pc + INSTR_BYTES, ras_underflow pulses, count stays 0.
  4. Accepted fetch with call_valid only: pc <= aligned call_pc, push pc + INSTR_BYTES.
  5. Accepted fetch with neither: pc <= pc + INSTR_BYTES.
- Simultaneous call and ret on an accepted fetch:
  - pc <= top entry (or the sequential PC if the RAS is empty).
  - The top entry is overwritten with pc + INSTR_BYTES; count is unchanged.
  - If the RAS was empty, count becomes 1 and ras_underflow pulses.
- RAS overflow: a push when full overwrites the oldest entry (circular). Count saturates at RAS_DEPTH; no error is flagged.
- Arithmetic: all PC additions are modulo 2^XLEN, so all-ones minus 3 plus 4 wraps to 0.
- misalign_err pulses the cycle after a used redirect_pc or call_pc has any nonzero low alignment bit.
- Reset asserted mid-operation takes effect immediately and discards RAS contents and any pending selection.

Decomposition:
- Package pc_fetch_pkg holds:
  - the next-PC source enum (SRC_HOLD, SRC_SEQ, SRC_REDIRECT, SRC_CALL, SRC_RET);
  - the ALIGN_BITS = log2(INSTR_BYTES) constant;
  - a function for the alignment mask.
- Sub-module pc_ras implements the circular stack:
  - inputs: push, pop, replace, flush, wdata;
  - outputs: top, empty, full, underflow.
- The top level keeps the PC register, the pc_valid flag and the priority mux.

Test Plan:
- Boot: release rst with fetch_ready = 1 -> cycle 1: pc = 0, pc_valid = 0; cycle 2: pc_valid = 1, pc = 0; then 4, 8, 12 on successive cycles.
- Stall and redirect: fetch_ready = 0 for 3 cycles at pc = 0x10 -> pc holds 0x10; redirect_valid with 0x203 during the stall -> next pc = 0x200 and misalign_err pulses for one cycle.
- Call/return: call at 0x100 to 0x400, then ret at 0x404 -> pc goes 0x400, 0x404, then 0x104; ras_empty returns to 1.
- Overflow: 5 nested calls with RAS_DEPTH = 4 -> ras_full = 1. Then 5 returns -> 4 correct return addresses (newest first), and the 5th return gives sequential pc with ras_underflow = 1.
- Simultaneous: call+ret on the same accepted fetch with top = 0x500 at pc = 0x300 -> pc = 0x500, new top = 0x304, count unchanged. Redirect with ras_flush -> ras_empty = 1.
- Wrap and async reset: pc = 0xFFFF_FFFC accepted -> pc = 0. Assert rst between clock edges -> pc = RESET_VEC immediately, without waiting for an edge.
